// File: rtl/clock_div_pkg.sv
// Shared constants and per-channel state type for the programmable clock divider.
// Holds the default WIDTH / N_CH / DEFAULT_DIV values used by clock_div_prog and
// clock_div_chan, the channel-state record (cnt, div, pend_div, pending) and its
// reset helper. State fields are CLK_DIV_MAX_WIDTH wide so one record type serves
// every WIDTH up to that limit. Bits above WIDTH are only ever loaded with zero.
package clock_div_pkg;

  localparam int unsigned CLK_DIV_WIDTH       = 16;
  localparam int unsigned CLK_DIV_N_CH        = 2;
  localparam int unsigned CLK_DIV_DEFAULT_DIV = 16;
  localparam int unsigned CLK_DIV_MAX_WIDTH   = 32;

  typedef struct packed {
    logic [CLK_DIV_MAX_WIDTH-1:0] cnt;
    logic [CLK_DIV_MAX_WIDTH-1:0] div;
    logic [CLK_DIV_MAX_WIDTH-1:0] pend_div;
    logic                         pending;
  } chan_state_t;

  // Channel state after reset: counter cleared, divisor at its default, nothing pending.
  function automatic chan_state_t chan_reset(input logic [CLK_DIV_MAX_WIDTH-1:0] d);
    chan_state_t s;
    s.cnt      = '0;
    s.div      = d;
    s.pend_div = '0;
    s.pending  = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: counter, active divisor, pending divisor and apply logic.
// Ports:
//   clk_in, rst   clock and synchronous active-high reset
//   en_i          run enable; low clears counter and output next cycle
//   sync_i        phase-align request; clears counter and output, keeps pending
//   wr_i          accepted, valid divisor write for this channel
//   wr_div_i      divisor carried by that write
//   pending_o     a written divisor is waiting to be applied
//   clk_out_o     divided output, clk_in / (2*div), 50% duty
//   tick_o        one-cycle pulse in the cycle clk_out_o rises
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int unsigned WIDTH       = CLK_DIV_WIDTH,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_div_i,
  output logic             pending_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam int unsigned SW = CLK_DIV_MAX_WIDTH;

  chan_state_t st_q, st_d;
  logic        clk_q, clk_d;
  logic        tick_q, tick_d;
  logic        wrap_c;

  // Next-state: write capture, then sync / stop / run with apply on the falling wrap.
  always_comb begin
    st_d   = st_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    wrap_c = (st_q.cnt == st_q.div - SW'(1));

    // The write port never targets a channel with a divisor pending, so a
    // capture here cannot coincide with an apply below.
    if (wr_i) begin
      st_d.pend_div = SW'(wr_div_i);
      st_d.pending  = 1'b1;
    end

    if (sync_i) begin
      st_d.cnt = '0;
      clk_d    = 1'b0;
    end else if (!en_i) begin
      st_d.cnt = '0;
      clk_d    = 1'b0;
      if (st_q.pending) begin
        st_d.div     = st_q.pend_div;
        st_d.pending = 1'b0;
      end
    end else if (wrap_c) begin
      st_d.cnt = '0;
      clk_d    = ~clk_q;
      tick_d   = ~clk_q;
      // Falling wrap: the new divisor starts a fresh low phase from cnt = 0.
      if (clk_q && st_q.pending) begin
        st_d.div     = st_q.pend_div;
        st_d.pending = 1'b0;
      end
    end else begin
      // Truncate to WIDTH so bits above WIDTH stay constant zero.
      st_d.cnt = SW'(WIDTH'(st_q.cnt + SW'(1)));
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      st_q   <= chan_reset(SW'(DEFAULT_DIV));
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pending_o = st_q.pending;
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clock_div_prog.sv
// Runtime-programmable multi-channel clock divider (clk_in / (2*D) per channel).
// Owns the divisor write port (decode, div_ready mux, div_err) and instantiates
// N_CH clock_div_chan channels.
// Optional feature: define CLK_DIV_SYNC_EN to add the 'sync' input, which clears
// every channel's counter and output next cycle for phase alignment.
// Ports:
//   clk_in, rst   clock and synchronous active-high reset
//   sync          (CLK_DIV_SYNC_EN only) phase-align all channels
//   en            per-channel run enable
//   div_wr        divisor write valid
//   div_ch        write target channel
//   div_val       new divisor
//   div_ready     combinational write accept, low while the target has a pending divisor
//   div_err       one-cycle pulse after an accepted write with div_val==0 or bad div_ch
//   clk_out       divided outputs, registered
//   tick          rising-edge pulses of clk_out, registered
module clock_div_prog
  import clock_div_pkg::*;
#(
  parameter  int unsigned WIDTH       = CLK_DIV_WIDTH,
  parameter  int unsigned N_CH        = CLK_DIV_N_CH,
  parameter  int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV,
  localparam int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic [N_CH-1:0]  en,
  input  logic             div_wr,
  input  logic [CH_W-1:0]  div_ch,
  input  logic [WIDTH-1:0] div_val,
  output logic             div_ready,
  output logic             div_err,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  localparam int unsigned NPAD = 1 << CH_W;

  logic [N_CH-1:0] pending;
  logic [NPAD-1:0] pend_pad;
  logic            sync_c;
  logic            ch_ok_c;
  logic            accept_c;
  logic            valid_c;
  logic            div_err_q, div_err_d;

`ifdef CLK_DIV_SYNC_EN
  assign sync_c = sync;
`else
  assign sync_c = 1'b0;
`endif

  // Out-of-range channel codes read as "not pending" so bad writes are accepted and flagged.
  assign pend_pad  = NPAD'(pending);
  assign div_ready = ~pend_pad[div_ch];
  assign ch_ok_c   = (32'(div_ch) < N_CH);
  assign accept_c  = div_wr & div_ready;
  assign valid_c   = accept_c & ch_ok_c & (div_val != '0);
  assign div_err_d = accept_c & ~valid_c;

  // Error pulse register.
  always_ff @(posedge clk_in) begin
    if (rst) div_err_q <= 1'b0;
    else     div_err_q <= div_err_d;
  end

  assign div_err = div_err_q;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    clock_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in    (clk_in),
      .rst       (rst),
      .en_i      (en[i]),
      .sync_i    (sync_c),
      .wr_i      (valid_c && (div_ch == CH_W'(i))),
      .wr_div_i  (div_val),
      .pending_o (pending[i]),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i])
    );
  end

endmodule
